// File: rtl/iir_biquad_mac_if.sv
// iir_biquad_mac_if: control, coefficient and sample handshake bundle for iir_biquad_mac
//   master: drives clear, coef_we/coef_addr/coef_data, in_valid/x_n, out_ready
//   slave : drives in_ready, out_valid/y_n, sat_flag, busy
interface iir_biquad_mac_if #(
    parameter int DW = 32,
    parameter int CW = 18
);
    logic          clear;
    logic          coef_we;
    logic [2:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_n;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y_n;
    logic          sat_flag;
    logic          busy;
    modport master (
        output clear, coef_we, coef_addr, coef_data, in_valid, x_n, out_ready,
        input  in_ready, out_valid, y_n, sat_flag, busy
    );
    modport slave (
        input  clear, coef_we, coef_addr, coef_data, in_valid, x_n, out_ready,
        output in_ready, out_valid, y_n, sat_flag, busy
    );
endinterface

// File: rtl/iir_biquad_mac.sv
// iir_biquad_mac: biquad IIR section, one shared multiplier over 5 MAC cycles per sample
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : iir_biquad_mac_if.slave (clear, coefficient writes, x_n/y_n handshakes, sat_flag, busy)
module iir_biquad_mac #(
    parameter int DW   = 32,
    parameter int CW   = 18,
    parameter int FRAC = 14
) (
    input logic              clk,
    input logic              rst_n,
    iir_biquad_mac_if.slave  bus
);
    localparam int AW = DW + CW + 3;
    localparam int PW = DW + CW;
    localparam logic signed [AW-1:0] L_HALF = AW'(2 ** (FRAC - 1));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SCALE, S_OUT} state_t;

    state_t               r_state;
    logic [2:0]           r_k;
    logic signed [DW-1:0] r_x, r_x1, r_x2, r_y1, r_y2, r_y;
    logic signed [AW-1:0] r_acc;
    logic signed [CW-1:0] r_sh [5];
    logic signed [CW-1:0] r_act [5];
    logic                 r_sat, r_ov;

    logic signed [DW-1:0] w_op;
    logic signed [CW-1:0] w_cf;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_term, w_biased, w_rnd;
    logic                 w_clip;
    logic signed [DW-1:0] w_ysat;

    always_comb begin
        w_op = r_k == 3'd0 ? r_x  : r_k == 3'd1 ? r_x1 : r_k == 3'd2 ? r_x2 : r_k == 3'd3 ? r_y1 : r_y2;
        w_cf = r_k == 3'd0 ? r_act[0] : r_k == 3'd1 ? r_act[1] : r_k == 3'd2 ? r_act[2] :
               r_k == 3'd3 ? r_act[3] : r_act[4];
    end

    assign w_prod   = PW'(w_op) * PW'(w_cf);
    assign w_term   = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    assign w_biased = r_acc + L_HALF;
    assign w_rnd    = w_biased >>> FRAC;
    // out of range when the bits above the output sign are not a pure sign extension
    assign w_clip   = w_rnd[AW-1:DW-1] != {(AW-DW+1){w_rnd[AW-1]}};
    assign w_ysat   = w_clip ? {w_rnd[AW-1], {(DW-1){~w_rnd[AW-1]}}} : w_rnd[DW-1:0];

    assign bus.in_ready  = r_state == S_IDLE;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.out_valid = r_ov;
    assign bus.y_n       = r_y;
    assign bus.sat_flag  = r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_sh    <= '{default: '0};
            r_act   <= '{default: '0};
            r_sat   <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            if (bus.coef_we && bus.coef_addr < 3'd5)
                r_sh[bus.coef_addr] <= bus.coef_data;
            if (bus.clear) begin
                r_state <= S_IDLE;
                r_ov    <= 1'b0;
                r_x1    <= '0;
                r_x2    <= '0;
                r_y1    <= '0;
                r_y2    <= '0;
                r_sat   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.in_valid) begin
                        r_x     <= bus.x_n;
                        r_act   <= r_sh;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end
                    S_MAC: begin
                        // terms 3 and 4 are the feedback taps, subtracted
                        r_acc   <= r_k >= 3'd3 ? r_acc - w_term : r_acc + w_term;
                        r_k     <= r_k + 3'd1;
                        r_state <= r_k == 3'd4 ? S_SCALE : S_MAC;
                    end
                    S_SCALE: begin
                        r_y     <= w_ysat;
                        r_x2    <= r_x1;
                        r_x1    <= r_x;
                        r_y2    <= r_y1;
                        r_y1    <= w_ysat;
                        r_sat   <= r_sat | w_clip;
                        r_ov    <= 1'b1;
                        r_state <= S_OUT;
                    end
                    S_OUT: if (bus.out_ready) begin
                        r_ov    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_mac.sv
// tb_iir_biquad_mac: directed scoreboard bench for iir_biquad_mac
module tb_iir_biquad_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    iir_biquad_mac_if #(.DW(32), .CW(18)) bus ();

    iir_biquad_mac #(.DW(32), .CW(18), .FRAC(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [17:0] d);
        @(negedge clk);
        bus.coef_we = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic collect(input string tag);
        int lat;
        logic [31:0] e;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 6);
        check({tag, "_out"}, {31'b0, bus.out_valid && sb.size() > 0}, 1);
        if (bus.out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, bus.y_n, e);
        end
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_sample(input string tag, input logic [31:0] x, input logic [31:0] exp,
                              input logic cw, input logic [2:0] ca, input logic [17:0] cd);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.x_n = x;
        bus.in_valid = 1'b1;
        bus.coef_we = cw;
        bus.coef_addr = ca;
        bus.coef_data = cd;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.coef_we = 1'b0;
        collect(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.clear = 0;
        bus.coef_we = 0;
        bus.coef_addr = 0;
        bus.coef_data = 0;
        bus.in_valid = 0;
        bus.x_n = 0;
        bus.out_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_y", bus.y_n, 0);
        check("rst_sat", {31'b0, bus.sat_flag}, 0);
        rst_n = 1'b1;

        // passthrough; writes to addresses 5 and 7 must be ignored
        write_coef(3'd0, 18'd16384);
        write_coef(3'd5, 18'd16384);
        write_coef(3'd7, 18'd16384);
        run_sample("pass0", 32'd1000, 32'd1000, 0, 0, 0);
        run_sample("pass1", -32'sd7, -32'sd7, 0, 0, 0);
        check("pass_sat", {31'b0, bus.sat_flag}, 0);

        // one-pole lowpass
        do_clear();
        write_coef(3'd0, 18'd8192);
        write_coef(3'd3, 18'h3E000);
        run_sample("pole0", 32'd1000, 32'd500, 0, 0, 0);
        run_sample("pole1", 32'd1000, 32'd750, 0, 0, 0);
        run_sample("pole2", 32'd1000, 32'd875, 0, 0, 0);
        run_sample("pole3", 32'd1000, 32'd938, 0, 0, 0);

        // saturation and sticky flag
        do_clear();
        write_coef(3'd0, 18'd131071);
        write_coef(3'd3, 18'd0);
        run_sample("satp", 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0);
        check("sat_set", {31'b0, bus.sat_flag}, 1);
        run_sample("satn", 32'h80000000, 32'h80000000, 0, 0, 0);
        check("sat_sticky", {31'b0, bus.sat_flag}, 1);
        do_clear();
        check("sat_cleared", {31'b0, bus.sat_flag}, 0);

        // backpressure
        write_coef(3'd0, 18'd16384);
        bus.out_ready = 0;
        run_sample("bp", 32'd1234, 32'd1234, 0, 0, 0);
        repeat (10) begin
            @(negedge clk);
            check("bp_y", bus.y_n, 32'd1234);
            check("bp_ov", {31'b0, bus.out_valid}, 1);
            check("bp_in_ready", {31'b0, bus.in_ready}, 0);
            bus.in_valid = 1'b1;
            bus.x_n = 32'd555;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        check("bp_ov_drop", {31'b0, bus.out_valid}, 0);
        check("bp_in_ready_back", {31'b0, bus.in_ready}, 1);
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        check("bp_ignored", cnt, 0);

        // shadow bank: write on the accept edge applies from the next sample
        run_sample("shadow0", 32'd1000, 32'd1000, 1, 3'd0, 18'd8192);
        run_sample("shadow1", 32'd1000, 32'd500, 0, 0, 0);

        // abort with clear during MAC
        write_coef(3'd3, 18'h3E000);
        do_clear();
        @(negedge clk);
        bus.x_n = 32'd9999;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'b0, bus.busy}, 1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        check("abort_no_out", cnt, 0);
        run_sample("abort_next", 32'd1000, 32'd500, 0, 0, 0);

        // reset during OUT
        bus.out_ready = 0;
        run_sample("pre_rst", 32'd77, 32'd289, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_ov", {31'b0, bus.out_valid}, 0);
        check("rst_out_y", bus.y_n, 0);
        check("rst_out_ready", {31'b0, bus.in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1;
        run_sample("post_rst", 32'd1000, 32'd0, 0, 0, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
